uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side control for the UART RX path. Sits directly downstream of edge_bit_counter: it consumes bit_cnt/edge_cnt and drives that block's enable.
- Oversamples RX_IN with a 3-sample majority vote, validates the start bit, deserializes LSB-first, checks parity and the stop bit, and emits P_DATA with a one-cycle data_valid pulse.

Parameters:
- DATA_WIDTH, 8, payload bits per frame. Fixed at 8 because the counter's frame lengths (10 bit times, or 11 with parity) assume 8.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high, already synchronized to CLK.
- prescale  in  6  oversampling ratio; legal values 8, 16, 32.
- par_en  in  1  1 = parity bit present.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- bit_cnt  in  4  from counter: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop (parity frames).
- edge_cnt  in  6  from counter: 0..prescale-1 within the current bit.
- edge_bit_counter_en  out  1  counter enable.
- P_DATA  out  8  last good byte.
- data_valid  out  1  one-cycle pulse per good frame.
- par_err  out  1  parity mismatch in the last frame.
- stp_err  out  1  stop bit sampled low in the last frame.

Behaviour:
- Reset values: state IDLE, edge_bit_counter_en=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, shift register=0, sample regs=0. Reset mid-frame aborts with no output. The counter shares RST, so both blocks restart aligned.
- edge_bit_counter_en is a Moore output: 1 in every state except IDLE. The first cycle after leaving IDLE sees edge_cnt=0, bit_cnt=0.
- M = prescale>>1. RX_IN is captured into s0/s1/s2 on the cycles where edge_cnt = M-1, M and M+1. The vote is majority(s0,s1,s2). The decision cycle is edge_cnt = M+2, which is always < prescale for legal values.
- The last stop bit is bit_cnt 9 if par_en=0, else bit_cnt 10. End-of-frame (EOF) is that bit with edge_cnt = prescale-1; the counter wraps to 0/0 at the next edge.
- IDLE: RX_IN=0 -> START. On the same transition par_err and stp_err clear to 0. Otherwise stay in IDLE.
- START: at decision, vote=0 -> DATA. Vote=1 (glitch) -> DRAIN.
- DATA: at each decision with bit_cnt 1..8, shift the vote into the MSB of the shift register (LSB-first line order). Once bit_cnt reaches 8 and the edge is prescale-1, go to PARITY if par_en=1, else STOP.
- PARITY: at decision, expected bit = XOR(shift) XOR par_typ; mismatch sets an internal perr. At edge prescale-1 -> STOP.
- STOP: at decision, vote=0 sets an internal serr. At EOF -> IDLE, and on the next cycle:
  - perr=0 and serr=0: data_valid=1 for exactly one cycle and P_DATA loads the shift register.
  - Otherwise: data_valid stays 0, P_DATA holds, par_err=perr, stp_err=serr.
- DRAIN: keeps the counter enabled and ignores RX_IN until EOF, then returns to IDLE with no outputs. This is required because the counter only clears by wrapping.
- Back-to-back frames: in the cycle data_valid pulses, IDLE may already detect RX_IN=0 for the next start bit.
- par_en, par_typ and prescale must be static while the state is not IDLE. Changing them mid-frame is undefined.
- par_err and stp_err hold their value until the next start detection.

Test Plan:
- prescale=8, par_en=0, byte 0xA5 at 8 clk/bit -> exactly one data_valid pulse, P_DATA=0xA5, 80 cycles after start detect; par_err=0, stp_err=0.
- prescale=16, par_en=1, par_typ=0, byte 0x3C with parity 0 -> data_valid once, P_DATA=0x3C. Repeat with the parity bit driven 1 -> no data_valid, par_err=1, P_DATA keeps 0x3C.
- prescale=8, byte 0x81 with stop bit driven low -> no data_valid, stp_err=1. Then a good frame 0x55 -> par_err and stp_err clear at its start, data_valid asserts, P_DATA=0x55.
- prescale=8, RX_IN low for 3 cycles then high -> DRAIN for 80 cycles, no data_valid. Counter at 0/0 with enable=0 afterwards; the next frame 0x12 is received correctly.
- prescale=32, RX_IN line with a single-cycle inverted glitch on the middle sample of every bit of byte 0xF0 -> majority vote rejects the glitches, P_DATA=0xF0.
- RST pulsed low during data bit 4 of a frame -> all outputs 0 immediately, counter 0/0. The next full frame 0x99 is received correctly with one data_valid pulse.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control. Majority-votes RX_IN around mid-bit,
// deserializes LSB-first and validates parity/stop using edge_bit_counter timing.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [3:0]            bit_cnt,
  input  logic [5:0]            edge_cnt,
  output logic                  edge_bit_counter_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DRAIN
  } state_e;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  state_e                  state_q, state_d;
  logic [2:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    perr_q, perr_d;
  logic                    serr_q, serr_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic [5:0] mid;
  logic       vote;
  logic       decide;
  logic       last_edge;
  logic       eof;
  logic       data_bit;

  assign mid       = {1'b0, prescale[5:1]};
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign decide    = (edge_cnt == mid + 6'd2);
  assign last_edge = (edge_cnt == prescale - 6'd1);
  assign eof       = last_edge && (bit_cnt == (par_en ? 4'd10 : 4'd9));
  assign data_bit  = (bit_cnt >= 4'd1) && (bit_cnt <= LAST_DATA_BIT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      samp_q       <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      serr_q       <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      serr_q       <= serr_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  // Three consecutive samples straddling mid-bit; the vote is read two edges later.
  always_comb begin
    samp_d = samp_q;
    if (state_q != IDLE) begin
      if (edge_cnt == mid - 6'd1) samp_d[0] = RX_IN;
      if (edge_cnt == mid)        samp_d[1] = RX_IN;
      if (edge_cnt == mid + 6'd1) samp_d[2] = RX_IN;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    serr_d       = serr_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    unique case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d   = START;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      START: begin
        if (decide) state_d = vote ? DRAIN : DATA;
      end
      DATA: begin
        if (decide && data_bit) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (last_edge && (bit_cnt == LAST_DATA_BIT)) state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (decide && (vote != ((^shift_q) ^ par_typ))) perr_d = 1'b1;
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        if (decide && !vote) serr_d = 1'b1;
        // Decision precedes EOF within the bit, so perr_q/serr_q are final here.
        if (eof) begin
          state_d = IDLE;
          if (!perr_q && !serr_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end else begin
            par_err_d = perr_q;
            stp_err_d = serr_q;
          end
        end
      end
      DRAIN: begin
        // The counter only clears by wrapping, so ride out a full frame.
        if (eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign edge_bit_counter_en = (state_q != IDLE);
  assign P_DATA              = p_data_q;
  assign data_valid          = data_valid_q;
  assign par_err             = par_err_q;
  assign stp_err             = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: behavioural edge_bit_counter, table of frames,
// scoreboard of expected frame results checked when the counter enable drops.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [3:0] bit_cnt;
  logic [5:0] edge_cnt;
  logic       en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    logic [5:0]  ps;
    logic        pe;
    logic        pt;
    logic [7:0]  data;
    logic        bad_par;
    logic        bad_stop;
    logic        glitch;
    logic        false_start;
    int unsigned gap;
    logic        exp_dv;
    logic [7:0]  exp_pd;
    logic        exp_pe;
    logic        exp_se;
  } vec_t;

  typedef struct {
    logic        dv;
    logic [7:0]  pd;
    logic        pe;
    logic        se;
    int unsigned len;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  vec_t tbl[10];

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .RX_IN               (RX_IN),
    .prescale            (prescale),
    .par_en              (par_en),
    .par_typ             (par_typ),
    .bit_cnt             (bit_cnt),
    .edge_cnt            (edge_cnt),
    .edge_bit_counter_en (en),
    .P_DATA              (P_DATA),
    .data_valid          (data_valid),
    .par_err             (par_err),
    .stp_err             (stp_err)
  );

  // Behavioural edge_bit_counter sharing RST with the DUT.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt  <= '0;
      edge_cnt <= '0;
    end else if (en) begin
      if (edge_cnt == prescale - 6'd1) begin
        edge_cnt <= '0;
        bit_cnt  <= (bit_cnt == (par_en ? 4'd10 : 4'd9)) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a frame ends when the enable falls; compare against the scoreboard.
  int unsigned run_len = 0;
  logic        prev_en = 1'b0;
  logic        prev_dv = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      run_len = 0;
      prev_en = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (prev_dv) check("dv_single_cycle", data_valid, 0);
      if (prev_en && !en) begin
        if (sb.size() == 0) begin
          check("sb_nonempty_at_frame_end", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          check("data_valid", data_valid, cur.dv);
          check("P_DATA", P_DATA, cur.pd);
          check("par_err", par_err, cur.pe);
          check("stp_err", stp_err, cur.se);
          check("frame_len", run_len, cur.len);
          check("cnt_wrapped", {bit_cnt, edge_cnt}, 0);
        end
      end else if (data_valid) begin
        check("dv_outside_frame_end", data_valid, 0);
      end
      run_len = en ? run_len + 1 : 0;
      prev_en = en;
      prev_dv = data_valid;
    end
  end

  task automatic drive_bit(input logic val, input logic [5:0] ps, input logic glitch);
    for (int i = 0; i < int'(ps); i++) begin
      RX_IN = (glitch && (i == int'(ps >> 1) + 1)) ? ~val : val;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    prescale = v.ps;
    par_en   = v.pe;
    par_typ  = v.pt;
    e.dv  = v.exp_dv;
    e.pd  = v.exp_pd;
    e.pe  = v.exp_pe;
    e.se  = v.exp_se;
    e.len = int'(v.ps) * (v.pe ? 11 : 10);
    sb.push_back(e);
    if (v.false_start) begin
      RX_IN = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      RX_IN = 1'b1;
    end else begin
      drive_bit(1'b0, v.ps, v.glitch);
      for (int b = 0; b < 8; b++) drive_bit(v.data[b], v.ps, v.glitch);
      if (v.pe) drive_bit((^v.data) ^ v.pt ^ v.bad_par, v.ps, v.glitch);
      drive_bit(~v.bad_stop, v.ps, v.glitch);
    end
    RX_IN = 1'b1;
    repeat (v.gap) begin @(posedge CLK); #1; end
  endtask

  initial begin
    vec_t rv;
    //          ps     pe    pt    data   bpar  bstop glit  fstrt gap  dv    pd     pe    se
    tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8,  1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{6'd8,  1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 8,  1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[4] = '{6'd8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b1, 8'h55, 1'b0, 1'b0};
    tbl[5] = '{6'd8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 90, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[6] = '{6'd8,  1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b1, 8'h12, 1'b0, 1'b0};
    tbl[7] = '{6'd32, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[8] = '{6'd16, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[9] = '{6'd16, 1'b1, 1'b1, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b1, 8'hE7, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_en", en, 0);
    check("rst_P_DATA", P_DATA, 0);
    check("rst_flags", {data_valid, par_err, stp_err}, 0);
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("idle_en", en, 0);

    for (int i = 0; i < 10; i++) send_frame(tbl[i]);

    // Reset in the middle of data bit 4: everything clears at once, no frame result.
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    rv       = '{6'd8, 1'b0, 1'b0, 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00, 1'b0, 1'b0};
    drive_bit(1'b0, 6'd8, 1'b0);
    for (int b = 0; b < 4; b++) drive_bit(rv.data[b], 6'd8, 1'b0);
    RX_IN = rv.data[4];
    repeat (4) begin @(posedge CLK); #1; end
    check("pre_rst_en", en, 1);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_en", en, 0);
    check("mid_rst_P_DATA", P_DATA, 0);
    check("mid_rst_flags", {data_valid, par_err, stp_err}, 0);
    check("mid_rst_cnt", {bit_cnt, edge_cnt}, 0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end

    rv = '{6'd8, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 8'h99, 1'b0, 1'b0};
    send_frame(rv);

    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(posedge CLK);
    repeat (4) @(posedge CLK);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
